framebuffer: RTL and testbench

FRAMEBUFFER -- requirements
Module: framebuffer

---
 rtl/framebuffer.sv | 158 +++++++++++++++
 tb/tb_framebuffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer.sv
// Double-buffered 16-bit framebuffer: writes land in the back bank, scanout
// streams the front bank in raster order over a valid/ready handshake, and
// a requested swap takes effect only at the frame boundary.
module framebuffer #(
    parameter int unsigned FB_WIDTH  = 400,
    parameter int unsigned FB_HEIGHT = 240
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(FB_WIDTH):0]      fb_x,
    input  logic [$clog2(FB_HEIGHT):0]     fb_y,
    input  logic [15:0]                    fb_color,
    input  logic                           fb_write,
    input  logic                           swap_req,
    output logic                           swap_pending,
    output logic                           front_sel,
    output logic [15:0]                    out_pixel,
    output logic [$clog2(FB_WIDTH)-1:0]    out_x,
    output logic [$clog2(FB_HEIGHT)-1:0]   out_y,
    output logic                           out_sof,
    output logic                           out_eol,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned XW    = $clog2(FB_WIDTH);
    localparam int unsigned YW    = $clog2(FB_HEIGHT);
    localparam int unsigned XIW   = XW + 1;
    localparam int unsigned YIW   = YW + 1;
    localparam int unsigned DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = 16;

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [PW-1:0]   r_mem0 [DEPTH];
    logic [PW-1:0]   r_mem1 [DEPTH];

    logic            r_front;
    logic            r_pending;
    logic            r_swap_d;
    logic            r_valid;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_sof;
    logic            r_eol;
    logic [PW-1:0]   r_pixel;
    logic [XW-1:0]   r_nx;
    logic [YW-1:0]   r_ny;

    logic            w_load;
    logic            w_xfer;
    logic            w_last;
    logic            w_apply;
    logic            w_front_nxt;
    logic            w_swap_edge;
    logic            w_wr_in;
    logic [AW-1:0]   w_waddr;
    logic [AW-1:0]   w_raddr;

    // Bounds check is done on the full-width coordinates so nothing aliases.
    assign w_wr_in     = (fb_x < XIW'(FB_WIDTH)) && (fb_y < YIW'(FB_HEIGHT));
    assign w_waddr     = AW'(fb_y) * AW'(FB_WIDTH) + AW'(fb_x);
    assign w_raddr     = AW'(r_ny) * AW'(FB_WIDTH) + AW'(r_nx);

    // Swap bookkeeping: the bank flips on the edge that retires the last pixel.
    assign w_swap_edge = swap_req & ~r_swap_d;
    assign w_xfer      = r_valid & out_ready;
    assign w_last      = w_xfer && (r_x == XW'(FB_WIDTH - 1)) && (r_y == YW'(FB_HEIGHT - 1));
    assign w_apply     = w_last & r_pending;
    assign w_front_nxt = r_front ^ w_apply;

    // Next-state and load decision; the prime state delays the first pixel one clock.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_PRIME: w_state_nxt = ST_RUN;
            ST_RUN:   w_load      = ~r_valid | out_ready;
            default:  w_state_nxt = ST_PRIME;
        endcase
    end

    // Write port into the back bank; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (!reset && fb_write && w_wr_in) begin
            if (r_front) begin
                r_mem0[w_waddr] <= fb_color;
            end else begin
                r_mem1[w_waddr] <= fb_color;
            end
        end
    end

    // Read port: fetches only when the output stage advances, using the bank that
    // will be front after this edge, so a stalled pixel never changes and the
    // first pixel after a swap already comes from the new bank.
    always_ff @(posedge clk) begin
        if (!reset && w_load) begin
            r_pixel <= w_front_nxt ? r_mem1[w_raddr] : r_mem0[w_raddr];
        end
    end

    // Control state, scan position and output stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_PRIME;
            r_front   <= 1'b0;
            r_pending <= 1'b0;
            r_swap_d  <= 1'b0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_sof     <= 1'b0;
            r_eol     <= 1'b0;
            r_nx      <= '0;
            r_ny      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_swap_d <= swap_req;
            r_front  <= w_front_nxt;
            if (w_apply) begin
                r_pending <= w_swap_edge;
            end else if (w_swap_edge) begin
                r_pending <= 1'b1;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_x     <= r_nx;
                r_y     <= r_ny;
                r_sof   <= (r_nx == '0) && (r_ny == '0);
                r_eol   <= (r_nx == XW'(FB_WIDTH - 1));
                if (r_nx == XW'(FB_WIDTH - 1)) begin
                    r_nx <= '0;
                    r_ny <= (r_ny == YW'(FB_HEIGHT - 1)) ? '0 : r_ny + YW'(1);
                end else begin
                    r_nx <= r_nx + XW'(1);
                end
            end
        end
    end

    assign swap_pending = r_pending;
    assign front_sel    = r_front;
    assign out_pixel    = r_pixel;
    assign out_x        = r_x;
    assign out_y        = r_y;
    assign out_sof      = r_sof;
    assign out_eol      = r_eol;
    assign out_valid    = r_valid;

endmodule

// File: tb/tb_framebuffer.sv
// Directed bench for framebuffer on a 16x8 frame: reset behaviour, full-frame
// streaming, writes and bounds, swaps at frame boundaries, backpressure and
// mid-frame reset.
module tb_framebuffer;

    localparam int unsigned W = 16;
    localparam int unsigned H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  fb_x;
    logic [3:0]  fb_y;
    logic [15:0] fb_color;
    logic        fb_write;
    logic        swap_req;
    logic        swap_pending;
    logic        front_sel;
    logic [15:0] out_pixel;
    logic [3:0]  out_x;
    logic [2:0]  out_y;
    logic        out_sof;
    logic        out_eol;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    framebuffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_color     (fb_color),
        .fb_write     (fb_write),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel),
        .out_pixel    (out_pixel),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_sof      (out_sof),
        .out_eol      (out_eol),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int x, input int y, input string tag);
        int n;
        n = 0;
        while (!(out_valid && out_x == x && out_y == y) && n < 400) begin
            step();
            n++;
        end
        chk(tag, 32'(out_valid && out_x == x && out_y == y), 32'd1);
    endtask

    task automatic wait_frame_end(input string tag);
        wait_pos(W - 1, H - 1, tag);
        step();
    endtask

    task automatic fill(input logic [15:0] base);
        for (int a = 0; a < int'(W * H); a++) begin
            fb_x     = 5'(a % W);
            fb_y     = 4'(a / W);
            fb_color = base + 16'(a);
            fb_write = 1'b1;
            step();
        end
        fb_write = 1'b0;
    endtask

    task automatic wr(input int x, input int y, input logic [15:0] c);
        fb_x     = 5'(x);
        fb_y     = 4'(y);
        fb_color = c;
        fb_write = 1'b1;
        step();
        fb_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int transfers, eols, sofs, gaps, order_err, flag_err, toggles;
        logic prev;
        logic [3:0]  tog_x;
        logic [2:0]  tog_y;
        logic        tog_sof;
        logic [15:0] tog_pix;

        reset = 1'b1; fb_x = '0; fb_y = '0; fb_color = '0; fb_write = 1'b0;
        swap_req = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        chk("rst_front", 32'(front_sel), 0);
        chk("rst_pending", 32'(swap_pending), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_x", 32'(out_x), 0);
        chk("rst_y", 32'(out_y), 0);

        reset = 1'b0;
        step();
        chk("start_valid_edge1", 32'(out_valid), 0);
        step();
        chk("start_valid_edge2", 32'(out_valid), 1);
        chk("start_x", 32'(out_x), 0);
        chk("start_y", 32'(out_y), 0);
        chk("start_sof", 32'(out_sof), 1);

        // One whole frame at full rate
        transfers = 0; eols = 0; sofs = 0; gaps = 0; order_err = 0; flag_err = 0;
        for (int i = 0; i < int'(W * H); i++) begin
            if (!out_valid) begin
                gaps++;
            end else begin
                transfers++;
                if (out_x != i % W || out_y != i / W) order_err++;
                if (out_sof != (out_x == 0 && out_y == 0)) flag_err++;
                if (out_eol != (out_x == W - 1)) flag_err++;
                eols += int'(out_eol);
                sofs += int'(out_sof);
            end
            step();
        end
        chk("frame_transfers", 32'(transfers), 128);
        chk("frame_eol", 32'(eols), 8);
        chk("frame_sof", 32'(sofs), 1);
        chk("frame_gaps", 32'(gaps), 0);
        chk("frame_order", 32'(order_err), 0);
        chk("frame_flags", 32'(flag_err), 0);
        chk("frame_wrap_x", 32'(out_x), 0);
        chk("frame_wrap_y", 32'(out_y), 0);

        // Fill back bank 1, then a pixel write and out-of-bounds writes
        fill(16'h1000);
        wr(5, 3, 16'hABCD);
        wr(16, 3, 16'h1235);
        wr(0, 8, 16'h1235);
        wr(31, 7, 16'h1235);
        chk("wr_front_unchanged", 32'(front_sel), 0);

        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("swap1_pending", 32'(swap_pending), 1);
        chk("swap1_front_before", 32'(front_sel), 0);
        wait_frame_end("swap1_reach_end");
        chk("swap1_front", 32'(front_sel), 1);
        chk("swap1_pending_clr", 32'(swap_pending), 0);
        chk("swap1_sof", 32'(out_sof), 1);
        chk("swap1_pix_0_0", 32'(out_pixel), 32'h1000);
        wait_pos(5, 3, "reach_5_3");
        chk("pix_5_3", 32'(out_pixel), 32'hABCD);
        wait_pos(0, 4, "reach_0_4");
        chk("pix_0_4", 32'(out_pixel), 32'h1040);
        wait_pos(15, 7, "reach_15_7");
        chk("pix_15_7", 32'(out_pixel), 32'h107F);
        chk("eol_15_7", 32'(out_eol), 1);

        // Backpressure at (10,0)
        wait_pos(10, 0, "reach_10_0");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_x", 32'(out_x), 10);
            chk("bp_y", 32'(out_y), 0);
            chk("bp_pix", 32'(out_pixel), 32'h100A);
            chk("bp_sof", 32'(out_sof), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_x", 32'(out_x), 11);
        chk("bp_next_pix", 32'(out_pixel), 32'h100B);

        // Fill bank 0, then hold swap_req high for 10 clocks
        fill(16'h2000);
        prev = front_sel;
        toggles = 0; tog_x = '1; tog_y = '1; tog_sof = 1'b0; tog_pix = '0;
        for (int i = 0; i < 300; i++) begin
            swap_req = (i < 10);
            step();
            if (front_sel != prev) begin
                if (toggles == 0) begin
                    tog_x = out_x; tog_y = out_y; tog_sof = out_sof; tog_pix = out_pixel;
                end
                toggles++;
                prev = front_sel;
            end
        end
        chk("held_toggles", 32'(toggles), 1);
        chk("held_tog_x", 32'(tog_x), 0);
        chk("held_tog_y", 32'(tog_y), 0);
        chk("held_tog_sof", 32'(tog_sof), 1);
        chk("held_tog_pix", 32'(tog_pix), 32'h2000);
        chk("held_front", 32'(front_sel), 0);
        chk("held_pending", 32'(swap_pending), 0);

        // Swap edge coincident with the final transfer waits a frame
        wait_pos(15, 7, "reach_late_edge");
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("late_front", 32'(front_sel), 0);
        chk("late_pending", 32'(swap_pending), 1);
        chk("late_pix_old_bank", 32'(out_pixel), 32'h2000);
        wait_frame_end("late_reach_end");
        chk("late_front_after", 32'(front_sel), 1);
        chk("late_pix_new_bank", 32'(out_pixel), 32'h1000);

        // Reset mid-frame with a write and a swap edge in the reset cycle
        wait_pos(12, 5, "reach_12_5");
        reset = 1'b1; fb_x = '0; fb_y = '0; fb_color = 16'hDEAD; fb_write = 1'b1; swap_req = 1'b1;
        step();
        chk("mid_rst_front", 32'(front_sel), 0);
        chk("mid_rst_pending", 32'(swap_pending), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_x", 32'(out_x), 0);
        chk("mid_rst_y", 32'(out_y), 0);
        reset = 1'b0; fb_write = 1'b0; swap_req = 1'b0;
        step();
        chk("mid_rel_valid1", 32'(out_valid), 0);
        step();
        chk("mid_rel_valid2", 32'(out_valid), 1);
        chk("mid_rel_x", 32'(out_x), 0);
        chk("mid_rel_y", 32'(out_y), 0);
        chk("mid_rel_sof", 32'(out_sof), 1);
        chk("mid_rel_pix", 32'(out_pixel), 32'h2000);
        chk("mid_rel_front", 32'(front_sel), 0);
        chk("mid_rel_pending", 32'(swap_pending), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
